mem_ctrl_param: RTL and testbench

Parametrised successor to the fixed 32x16 single-port RAM. Adds configurable width, depth and read latency, plus byte-strobe writes and a valid/ready request handshake. Runs an automatic zero-initialisation sweep after reset and on request, and returns a per-request response code. It sits under the same memory interface and environment, replacing the fixed-geometry memory as the DUV.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_lat_pipe.sv | 38 +++
 rtl/mem_ctrl_param.sv | 144 ++++++++++++++
 tb/tb_mem_ctrl_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the parametrised single-port memory controller:
// response codes, FSM states and the response-beat width helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OKAY     = 2'b00,
        ERR_ADDR = 2'b01,
        ERR_CMD  = 2'b10,
        RSVD     = 2'b11
    } resp_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int RESP_W = 2;

    // Packed width of one response beat {valid, rdata, response}.
    function automatic int beat_w(input int data_w);
        return 1 + data_w + RESP_W;
    endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// RD_LAT-deep shift register of response beats; reset empties every stage so
// in-flight responses are dropped.
module mem_lat_pipe
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [beat_w(DATA_W)-1:0]   din,
    output logic [beat_w(DATA_W)-1:0]   dout
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        resp_e             response;
    } resp_beat_t;

    resp_beat_t stage [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[RD_LAT-1];

endmodule

// File: rtl/mem_ctrl_param.sv
// Parametrised single-port RAM with byte strobes, valid/ready requests,
// fixed-latency coded responses and a zero-init sweep after reset or clear.
//
//   state | meaning
//   INIT  | sweeping zeros into mem[init_cnt], one word per cycle; no requests
//   RUN   | accepting one request per cycle; clear re-enters INIT
module mem_ctrl_param
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            response,
    output logic                  init_done
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1    = ADDR_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = AW1'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        resp_e             response;
    } resp_beat_t;

    state_e            state;
    state_e            state_nxt;
    logic [IDX_W-1:0]  init_cnt;
    logic              init_we;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              cmd_err;
    logic              addr_err;
    logic              do_wr;
    logic [IDX_W-1:0]  idx;
    resp_beat_t        beat_in;
    resp_beat_t        beat_out;

    // init_cnt is parked at zero in RUN so a clear always restarts the sweep at word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end else begin
                init_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (init_cnt == LAST_IDX) state_nxt = RUN;
            RUN:  if (clear) state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        init_we   = 1'b0;
        case (state)
            INIT: init_we = 1'b1;
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
        endcase
    end

    assign accept   = req_valid && req_ready;
    assign idx      = addr[IDX_W-1:0];
    assign cmd_err  = (wr == rd);
    assign addr_err = ({1'b0, addr} >= DEPTH_A);
    assign do_wr    = accept && !cmd_err && !addr_err && wr;

    // Sweep writes and request writes never coincide: requests are only taken in RUN.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (do_wr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands; a zero beat means "no response".
    always_comb begin
        beat_in = '0;
        if (accept) begin
            beat_in.valid = 1'b1;
            if (cmd_err) begin
                beat_in.response = ERR_CMD;
            end else if (addr_err) begin
                beat_in.response = ERR_ADDR;
            end else begin
                beat_in.response = OKAY;
                if (rd) begin
                    beat_in.rdata = mem[idx];
                end
            end
        end
    end

    mem_lat_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk   (clk),
        .rst_n (reset),
        .din   (beat_in),
        .dout  (beat_out)
    );

    assign rsp_valid = beat_out.valid;
    assign rdata     = beat_out.rdata;
    assign response  = beat_out.response;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Scoreboard bench: two controllers (RD_LAT=1 and RD_LAT=3) driven by the same
// directed requests; a negedge monitor pops expected beats as responses fall due.
module tb_mem_ctrl_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        rdy1, rv1, idn1, rdy3, rv3, idn3;
    logic [31:0] rdat1, rdat3;
    logic [1:0]  resp1, resp3;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ncyc = 0;

    always #5 clk = ~clk;

    mem_ctrl_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(rdy1),
        .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rsp_valid(rv1), .rdata(rdat1), .response(resp1), .init_done(idn1)
    );

    mem_ctrl_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(rdy3),
        .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rsp_valid(rv3), .rdata(rdat3), .response(resp3), .init_done(idn3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic mon_beat(input string nm, input logic v, input logic [31:0] d,
                            input logic [1:0] r, input bit have, input exp_t h, output bit pop);
        pop = 1'b0;
        if (have && h.due == ncyc) begin
            pop = 1'b1;
            chk({nm, " rsp_valid"}, 32'(v), 32'd1);
            if (v) begin
                chk({nm, " rdata"}, d, h.rdata);
                chk({nm, " response"}, 32'(r), 32'(h.resp));
            end
        end else if (have && h.due < ncyc) begin
            pop = 1'b1;
            chk({nm, " late expectation"}, 32'(ncyc), 32'(h.due));
        end else if (v) begin
            chk({nm, " unexpected rsp_valid"}, 32'(v), 32'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t h;
        bit   pop;
        ncyc++;
        h = '{32'd0, 2'd0, -1};
        if (q1.size() > 0) h = q1[0];
        mon_beat("lat1", rv1, rdat1, resp1, q1.size() > 0, h, pop);
        if (pop) void'(q1.pop_front());
        h = '{32'd0, 2'd0, -1};
        if (q3.size() > 0) h = q3[0];
        mon_beat("lat3", rv3, rdat3, resp3, q3.size() > 0, h, pop);
        if (pop) void'(q3.pop_front());
    end

    // Called just after a negedge; the request is accepted at the next posedge.
    task automatic issue(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic c, input logic [31:0] ed, input logic [1:0] er);
        exp_t e;
        req_valid = 1'b1; wr = w; rd = r; addr = a; wdata = d; wstrb = s; clear = c;
        e.rdata = ed;
        e.resp  = er;
        e.due   = ncyc + 1;
        q1.push_back(e);
        e.due   = ncyc + 3;
        q3.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; wr = 1'b0; rd = 1'b0; clear = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    // Checks the 16-cycle sweep window, starting 0 posedges after reset release or clear.
    task automatic wait_init(input string nm);
        req_valid = 1'b0; wr = 1'b0; rd = 1'b0; clear = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            chk({nm, " req_ready lat1"}, 32'(rdy1), 32'(i == 16));
            chk({nm, " req_ready lat3"}, 32'(rdy3), 32'(i == 16));
            chk({nm, " init_done lat1"}, 32'(idn1), 32'(i == 16));
            chk({nm, " init_done lat3"}, 32'(idn3), 32'(i == 16));
            if (i < 16) begin
                @(negedge clk); #1;
            end
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, " req_ready lat1"}, 32'(rdy1), 32'd0);
        chk({nm, " rsp_valid lat1"}, 32'(rv1), 32'd0);
        chk({nm, " rdata lat1"}, rdat1, 32'd0);
        chk({nm, " response lat1"}, 32'(resp1), 32'd0);
        chk({nm, " init_done lat1"}, 32'(idn1), 32'd0);
        chk({nm, " req_ready lat3"}, 32'(rdy3), 32'd0);
        chk({nm, " rsp_valid lat3"}, 32'(rv3), 32'd0);
        chk({nm, " rdata lat3"}, rdat3, 32'd0);
        chk({nm, " response lat3"}, 32'(resp3), 32'd0);
        chk({nm, " init_done lat3"}, 32'(idn3), 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #2 reset = 1'b0;
        #1 chk_zero_outputs("reset");
        @(negedge clk); #1;
        reset = 1'b1;
        wait_init("post-reset");

        for (int a = 0; a < 16; a++) begin
            issue(1'b0, 1'b1, 5'(a), 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);
        end

        issue(1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 4'b1111, 1'b0, 32'd0, 2'b00);
        issue(1'b1, 1'b0, 5'd3, 32'h000000AA, 4'b0001, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd3, 32'd0, 4'h0, 1'b0, 32'hDEADBEAA, 2'b00);

        issue(1'b0, 1'b1, 5'd16, 32'd0, 4'h0, 1'b0, 32'd0, 2'b01);
        issue(1'b1, 1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 2'b10);
        issue(1'b0, 1'b0, 5'd2, 32'd0, 4'h0, 1'b0, 32'd0, 2'b10);
        issue(1'b1, 1'b0, 5'd16, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 2'b01);
        issue(1'b0, 1'b1, 5'd0, 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd3, 32'd0, 4'h0, 1'b0, 32'hDEADBEAA, 2'b00);
        issue(1'b1, 1'b0, 5'd15, 32'h12345678, 4'b1010, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd15, 32'd0, 4'h0, 1'b0, 32'h12005600, 2'b00);

        for (int a = 0; a < 8; a++) begin
            issue(1'b1, 1'b0, 5'(a), 32'h10 + 32'(a), 4'hF, 1'b0, 32'd0, 2'b00);
        end
        for (int a = 0; a < 8; a++) begin
            issue(1'b0, 1'b1, 5'(a), 32'd0, 4'h0, 1'b0, 32'h10 + 32'(a), 2'b00);
        end

        issue(1'b1, 1'b0, 5'd5, 32'h00000055, 4'hF, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd5, 32'd0, 4'h0, 1'b1, 32'h00000055, 2'b00);
        wait_init("post-clear");
        issue(1'b0, 1'b1, 5'd5, 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd3, 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);
        issue(1'b0, 1'b1, 5'd15, 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);

        issue(1'b1, 1'b0, 5'd4, 32'h00000044, 4'hF, 1'b0, 32'd0, 2'b00);
        idle(4);
        issue(1'b0, 1'b1, 5'd4, 32'd0, 4'h0, 1'b0, 32'h00000044, 2'b00);
        issue(1'b0, 1'b1, 5'd4, 32'd0, 4'h0, 1'b0, 32'h00000044, 2'b00);
        issue(1'b0, 1'b1, 5'd4, 32'd0, 4'h0, 1'b0, 32'h00000044, 2'b00);
        // The last two RD_LAT=3 reads are still in flight and must never respond.
        reset = 1'b0;
        q1.delete();
        q3.delete();
        #1 chk_zero_outputs("mid-stream reset");
        idle(3);
        reset = 1'b1;
        wait_init("re-init");
        issue(1'b0, 1'b1, 5'd4, 32'd0, 4'h0, 1'b0, 32'd0, 2'b00);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
